// File: rtl/alu_issue_seq.sv
// alu_issue_seq: sequences one request at a time onto a shared combinational ALU.
// Single ops take one EXEC cycle; MULA (acc + a*b) runs WIDTH shift-add steps
// through the same ALU; undecodable R-type function codes complete immediately
// with err set.
//
// Ports:
//   CLK, Reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (ready only in IDLE, low during Reset)
//   ALUop, FuncCode       opcode-derived op; ALUop 4'b1111 selects FuncCode decode
//   op_a, op_b, op_c      operands; op_c is the MULA accumulator seed
//   out_valid / out_ready result handshake; result and err held while out_valid
//   alu_ctrl, alu_a/b     drive to the shared ALU (zero outside EXEC/MUL)
//   alu_result            combinational ALU result
//   busy                  high in any state other than IDLE
module alu_issue_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUop,
    input  logic [5:0]       FuncCode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    localparam int unsigned STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_MULA = 4'b0101;
    localparam logic [3:0] OP_RTYPE  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          ctrl_q;
    logic [WIDTH-1:0]    op_a_q, op_b_q;
    logic [WIDTH-1:0]    acc_q;
    logic [STEP_W-1:0]   step_q;
    logic [3:0]          dec_ctrl;
    logic                dec_illegal;
    logic                accept;
    logic                last_step;

    // Status outputs derive directly from the state register.
    assign in_ready  = (state_q == IDLE) && !Reset;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last_step = (step_q == STEP_W'(WIDTH - 1));

    // Opcode / function-field decode of the live request.
    always_comb begin
        dec_ctrl    = ALUop;
        dec_illegal = 1'b0;
        if (ALUop == OP_RTYPE) begin
            dec_ctrl = 4'b0000;
            case (FuncCode)
                6'b000000: dec_ctrl = 4'b0011;
                6'b000010: dec_ctrl = 4'b0100;
                6'b100000: dec_ctrl = 4'b0010;
                6'b100010: dec_ctrl = 4'b0110;
                6'b100100: dec_ctrl = 4'b0000;
                6'b100101: dec_ctrl = 4'b0001;
                6'b101010: dec_ctrl = 4'b0111;
                6'b111000: dec_ctrl = 4'b0101;
                6'b101011: dec_ctrl = 4'b1011;
                6'b100111: dec_ctrl = 4'b1100;
                6'b100110: dec_ctrl = 4'b1010;
                6'b100011: dec_ctrl = 4'b1001;
                6'b100001: dec_ctrl = 4'b1000;
                6'b000011: dec_ctrl = 4'b1101;
                default:   dec_illegal = 1'b1;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and ALU drive; the ALU is idle (all zero) outside EXEC/MUL.
    always_comb begin
        state_d  = state_q;
        alu_ctrl = 4'b0000;
        alu_a    = '0;
        alu_b    = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_illegal) begin
                        state_d = DONE;
                    end else if (dec_ctrl == CTRL_MULA) begin
                        state_d = MUL;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                alu_ctrl = ctrl_q;
                alu_a    = op_a_q;
                alu_b    = op_b_q;
                state_d  = DONE;
            end
            MUL: begin
                // One shift-add partial product per step, accumulated by the ALU.
                alu_ctrl = CTRL_ADD;
                alu_a    = acc_q;
                alu_b    = op_b_q[step_q] ? (op_a_q << step_q) : '0;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, accumulator/step tracking and result registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ctrl_q <= 4'b0000;
            op_a_q <= '0;
            op_b_q <= '0;
            acc_q  <= '0;
            step_q <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ctrl_q <= dec_ctrl;
                        op_a_q <= op_a;
                        op_b_q <= op_b;
                        err    <= dec_illegal;
                        if (dec_illegal) begin
                            result <= '0;
                        end else if (dec_ctrl == CTRL_MULA) begin
                            acc_q  <= op_c;
                            step_q <= '0;
                        end
                    end
                end
                EXEC: begin
                    result <= alu_result;
                end
                MUL: begin
                    acc_q  <= alu_result;
                    step_q <= step_q + STEP_W'(1);
                    if (last_step) begin
                        result <= alu_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
module tb_alu_issue_seq;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUop;
    logic [5:0]  FuncCode;
    logic [31:0] op_a, op_b, op_c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        err;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_issue_seq #(.WIDTH(32)) dut (
        .CLK(CLK), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .FuncCode(FuncCode),
        .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // External ALU model.
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: alu_fn = a & b;
            4'b0001: alu_fn = a | b;
            4'b0010: alu_fn = a + b;
            4'b0110: alu_fn = a - b;
            4'b0111: alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: alu_fn = ~(a | b);
            4'b1010: alu_fn = a ^ b;
            default: alu_fn = a ^ b ^ {28'd0, c};
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a request for one accept edge, then scramble the inputs.
    task automatic do_accept(input logic [3:0] aop, input logic [5:0] fc,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        ALUop = aop; FuncCode = fc; op_a = a; op_b = b; op_c = c;
        in_valid = 1'b1;
        #1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        ALUop = 4'b1111; FuncCode = 6'b111111;
        op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D; op_c = 32'h1234_5678;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_single(input string tag, input logic [3:0] aop, input logic [5:0] fc,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] exp_ctrl, input logic [31:0] exp_res);
        do_accept(aop, fc, a, b, 32'd0);
        check({tag, "_ctrl"}, 32'(alu_ctrl), 32'(exp_ctrl));
        check({tag, "_alu_a"}, alu_a, a);
        check({tag, "_alu_b"}, alu_b, b);
        check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_ctrl_done"}, 32'(alu_ctrl), 32'd0);
        handshake();
    endtask

    task automatic run_mula(input string tag, input logic [3:0] aop, input logic [5:0] fc,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [31:0] exp_res);
        do_accept(aop, fc, a, b, c);
        for (int k = 0; k < 32; k++) begin
            check({tag, "_step_ctrl"}, 32'(alu_ctrl), 32'b0010);
            check({tag, "_step_alu_b"}, alu_b, b[k] ? (a << k) : 32'd0);
            check({tag, "_step_valid"}, 32'(out_valid), 32'd0);
            if (k == 0) check({tag, "_seed"}, alu_a, c);
            tick();
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_err"}, 32'(err), 32'd0);
        handshake();
    endtask

    logic [5:0] fc_tab [13];
    logic [3:0] ct_tab [13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fc_tab = '{6'b000000, 6'b000010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                   6'b101011, 6'b100111, 6'b100110, 6'b100011, 6'b100001, 6'b000011};
        ct_tab = '{4'b0011, 4'b0100, 4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                   4'b1011, 4'b1100, 4'b1010, 4'b1001, 4'b1000, 4'b1101};
        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALUop = 4'd0; FuncCode = 6'd0; op_a = 32'd0; op_b = 32'd0; op_c = 32'd0;

        // Reset held over several cycles.
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        Reset = 1'b0;
        #1;
        check("rst_release_ready", 32'(in_ready), 32'd1);

        // R-type add 5+7.
        run_single("add", 4'b1111, 6'b100000, 32'd5, 32'd7, 4'b0010, 32'd12);

        // MULA 10 + 3*4.
        run_mula("mula", 4'b1111, 6'b111000, 32'd3, 32'd4, 32'd10, 32'd22);

        // Undecodable function code.
        do_accept(4'b1111, 6'b111111, 32'd9, 32'd9, 32'd9);
        check("ill_valid", 32'(out_valid), 32'd1);
        check("ill_result", result, 32'd0);
        check("ill_err", 32'(err), 32'd1);
        check("ill_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("ill_alu_a", alu_a, 32'd0);
        handshake();

        // OR with held result under backpressure.
        do_accept(4'b0001, 6'b000000, 32'hF0, 32'h0F, 32'd0);
        check("or_ctrl", 32'(alu_ctrl), 32'b0001);
        tick();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; ALUop = 4'b0010; op_a = 32'd1; op_b = 32'd1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", result, 32'hFF);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("hold_result_end", result, 32'hFF);
        handshake();

        // out_ready held high outside DONE does not shorten the operation.
        out_ready = 1'b1;
        do_accept(4'b0110, 6'b000000, 32'd10, 32'd3, 32'd0);
        check("sub_exec_valid", 32'(out_valid), 32'd0);
        check("sub_exec_busy", 32'(busy), 32'd1);
        tick();
        check("sub_valid", 32'(out_valid), 32'd1);
        check("sub_result", result, 32'd7);
        tick();
        check("sub_done_gone", 32'(out_valid), 32'd0);
        check("sub_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Reset during MUL step 10 discards the operation.
        do_accept(4'b1111, 6'b111000, 32'd3, 32'd4, 32'd10);
        for (int k = 0; k < 10; k++) tick();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_ctrl", 32'(alu_ctrl), 32'b0010);
        Reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_ctrl", 32'(alu_ctrl), 32'd0);
        Reset = 1'b0;
        #1;
        check("mid_rel_ready", 32'(in_ready), 32'd1);
        run_single("post_rst_add", 4'b0010, 6'b000000, 32'd1, 32'd2, 4'b0010, 32'd3);

        // MULA wrap-around and direct ALUop form.
        run_mula("wrap", 4'b1111, 6'b111000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
        run_mula("mula_op", 4'b0101, 6'b000000, 32'h1234_5678, 32'd9, 32'h100, 32'hA3D7_0B38);

        // Full R-type decode table (MULA excluded).
        for (int i = 0; i < 13; i++) begin
            run_single("dec", 4'b1111, fc_tab[i], 32'h0000_00F0, 32'h0000_003C,
                       ct_tab[i], alu_fn(ct_tab[i], 32'h0000_00F0, 32'h0000_003C));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_seq.md
ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; all data ports SHALL be WIDTH bits.
REQ-002 CLK  input  1  sole clock, rising-edge.
REQ-003 Reset  input  1  synchronous, active-high reset; sampled on CLK rising edge only.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 ALUop  input  4  opcode-derived ALU op; 4'b1111 = R-type, decode FuncCode.
REQ-007 FuncCode  input  6  R-type function field.
REQ-008 op_a, op_b, op_c  input  WIDTH  operands; op_c = accumulator for MULA.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  completed result.
REQ-012 err  output  1  undecodable R-type FuncCode; qualified by out_valid.
REQ-013 alu_ctrl  output  4  control code driven to the shared ALU.
REQ-014 alu_a, alu_b  output  WIDTH  ALU operand drives.
REQ-015 alu_result  input  WIDTH  combinational ALU result.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, MUL, DONE; encoding free.
REQ-018 in_ready SHALL equal 1 in IDLE only; accept = in_valid & in_ready at rising edge.
REQ-019 On accept, ALUop, FuncCode, op_a, op_b, op_c SHALL be registered; inputs ignored afterwards until next accept.
REQ-020 Decode: ALUop != 4'b1111 -> ctrl = ALUop; ALUop = 4'b1111 -> FuncCode map 000000->0011, 000010->0100, 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 111000->0101 (MULA), 101011->1011, 100111->1100, 100110->1010, 100011->1001, 100001->1000, 000011->1101.
REQ-021 Unmapped R-type FuncCode: next state DONE, result = 0, err = 1, ALU not driven (alu_ctrl = 0, operands 0).
REQ-022 Decoded ctrl != 0101: IDLE -> EXEC; in EXEC alu_ctrl = ctrl, alu_a = op_a, alu_b = op_b; alu_result captured into result at end of EXEC; EXEC -> DONE; err = 0.
REQ-023 Decoded ctrl = 0101 (MULA, incl. ALUop = 0101): IDLE -> MUL; P <= op_c, step i <= 0.
REQ-024 In MUL step i: alu_ctrl = 0010, alu_a = P, alu_b = (op_b[i] ? op_a << i : 0); P <= alu_result; i increments.
REQ-025 MUL SHALL run exactly WIDTH steps regardless of op_b zero bits; after step WIDTH-1, result <= alu_result, MUL -> DONE; result = (op_c + op_a*op_b) mod 2^WIDTH.
REQ-026 Latency accept-edge to out_valid: 1 cycle (illegal), 2 cycles (single op), WIDTH+1 cycles (MULA).
REQ-027 DONE: out_valid = 1, result/err held stable until out_valid & out_ready at a rising edge, then -> IDLE.
REQ-028 out_ready high while not in DONE SHALL have no effect.
REQ-029 Outside EXEC/MUL, alu_ctrl, alu_a, alu_b SHALL be 0.
REQ-030 No back-to-back overlap: next accept no earlier than cycle after DONE handshake.
REQ-031 ALU arithmetic/overflow behaviour belongs to ALU; block SHALL pass alu_result unmodified.

Reset
REQ-032 Reset high at a rising edge SHALL force IDLE, out_valid = 0, result = 0, err = 0, P = 0, i = 0, busy = 0, in_ready = 1 on next cycle.
REQ-033 Reset SHALL take priority over accept and out handshake in the same cycle; an in-flight MULA or held DONE result SHALL be discarded.
REQ-034 Reset held across multiple cycles SHALL keep all outputs at reset values; in_ready SHALL be 0 while Reset is high.

Verification
REQ-035 ALUop=1111, FuncCode=100000, op_a=5, op_b=7, ALU model -> alu_ctrl=0010 in EXEC, out_valid 2 cycles after accept, result=12, err=0.
REQ-036 ALUop=1111, FuncCode=111000, op_a=3, op_b=4, op_c=10 -> 32 MUL cycles with alu_ctrl=0010, result=22 at cycle 33, err=0.
REQ-037 ALUop=1111, FuncCode=111111 -> out_valid 1 cycle after accept, result=0, err=1, alu_ctrl stays 0.
REQ-038 ALUop=0001, op_a=0xF0, op_b=0x0F -> alu_ctrl=0001, result=0xFF; hold out_ready=0 5 cycles -> result stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-039 Reset asserted at MUL step 10 of a MULA -> next cycle IDLE, out_valid=0, in_ready=1 after Reset low; following add request completes normally.
REQ-040 MULA with op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, op_c=0 -> result=0x00000001 (wrap mod 2^32).
